// File: rtl/pc_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset/bubble constants,
// FSM state encoding and the IF/ID payload layout.
package pc_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    // 97-bit IF/ID payload: pc, pc+4, instruction, valid
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
    } if_id_t;

    function automatic if_id_t make_bubble(input logic [31:0] nop_instr);
        if_id_t b;
        b.pc    = 32'h0;
        b.pc4   = 32'h0;
        b.instr = nop_instr;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/pc_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset/bubble inserts a NOP, load captures a new
// fetch, otherwise the contents hold.
module if_id_reg
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_load,
    input  logic   i_bubble,
    input  if_id_t i_data,
    output if_id_t o_data
);

    if_id_t r_data;

    // Bubble wins over load so a squash can never be lost to a concurrent fetch.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_bubble) begin
            r_data <= make_bubble(NOP_INSTR);
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_data = r_data;

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, redirect/stall/flush priority, BOOT/FETCH/HALTED
// control and the IF/ID register feeding decode.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic        i_halt_req,
    input  logic [31:0] i_pc_plus4,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_if_id_pc,
    output logic [31:0] o_if_id_pc4,
    output logic [31:0] o_if_id_instr,
    output logic        o_if_id_valid,
    output logic        o_halted,
    output logic        o_misalign_err
);

    fetch_state_e r_state;
    logic [31:0]  r_pc;
    logic         r_halted;
    logic         r_misalign;

    logic   w_load;
    logic   w_bubble;
    if_id_t w_fetch;
    if_id_t w_if_id;

    // Redirect and halt both squash IF/ID; stall freezes it and masks flush.
    always_comb begin
        w_load   = 1'b0;
        w_bubble = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (i_branch_taken || i_halt_req) begin
                    w_bubble = 1'b1;
                end else if (!i_stall) begin
                    if (i_flush) begin
                        w_bubble = 1'b1;
                    end else begin
                        w_load = 1'b1;
                    end
                end
            end
            default: w_bubble = 1'b1;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_halted   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_misalign <= 1'b0;
            case (r_state)
                ST_BOOT: r_state <= ST_FETCH;
                ST_FETCH: begin
                    if (i_branch_taken) begin
                        r_pc       <= {i_branch_target[31:2], 2'b00};
                        r_misalign <= |i_branch_target[1:0];
                    end else if (i_halt_req) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end else if (!i_stall) begin
                        r_pc <= i_pc_plus4;
                    end
                end
                ST_HALTED: r_state <= ST_HALTED;
                default:   r_state <= ST_BOOT;
            endcase
        end
    end

    assign w_fetch.pc    = r_pc;
    assign w_fetch.pc4   = i_pc_plus4;
    assign w_fetch.instr = i_imem_rdata;
    assign w_fetch.valid = 1'b1;

    if_id_reg #(
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_bubble(w_bubble),
        .i_data  (w_fetch),
        .o_data  (w_if_id)
    );

    assign o_pc_out       = r_pc;
    assign o_if_id_pc     = w_if_id.pc;
    assign o_if_id_pc4    = w_if_id.pc4;
    assign o_if_id_instr  = w_if_id.instr;
    assign o_if_id_valid  = w_if_id.valid;
    assign o_halted       = r_halted;
    assign o_misalign_err = r_misalign;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_pc_fetch_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, branchTaken, haltReq;
    logic [31:0] branchTarget;

    logic [31:0] pcOut, pcPlus4, imemRdata, ifIdPc, ifIdPc4, ifIdInstr;
    logic        ifIdValid, halted, misErr;

    logic [31:0] wPcOut, wPcPlus4, wImem, wIfIdPc, wIfIdPc4, wIfIdInstr;
    logic        wIfIdValid, wHalted, wMisErr;

    int nChecks = 0;
    int nFails  = 0;

    function automatic logic [31:0] imemFn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // Environment: PC+4 adder and a combinational instruction memory.
    assign pcPlus4   = pcOut + 32'd4;
    assign imemRdata = imemFn(pcOut);
    assign wPcPlus4  = wPcOut + 32'd4;
    assign wImem     = imemFn(wPcOut);

    pc_fetch_stage dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
        .i_branch_taken(branchTaken), .i_branch_target(branchTarget),
        .i_halt_req(haltReq), .i_pc_plus4(pcPlus4), .i_imem_rdata(imemRdata),
        .o_pc_out(pcOut), .o_if_id_pc(ifIdPc), .o_if_id_pc4(ifIdPc4),
        .o_if_id_instr(ifIdInstr), .o_if_id_valid(ifIdValid),
        .o_halted(halted), .o_misalign_err(misErr)
    );

    pc_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
        .i_branch_taken(branchTaken), .i_branch_target(branchTarget),
        .i_halt_req(haltReq), .i_pc_plus4(wPcPlus4), .i_imem_rdata(wImem),
        .o_pc_out(wPcOut), .o_if_id_pc(wIfIdPc), .o_if_id_pc4(wIfIdPc4),
        .o_if_id_instr(wIfIdInstr), .o_if_id_valid(wIfIdValid),
        .o_halted(wHalted), .o_misalign_err(wMisErr)
    );

    // Behavioural model of the main instance (RESET_PC = 0).
    logic [31:0] mPc, mIfPc, mIfPc4, mIfInstr;
    logic        mValid, mHalted, mBoot, mMis;

    task automatic modelBubble();
        mIfPc = 32'h0; mIfPc4 = 32'h0; mIfInstr = 32'h13; mValid = 1'b0;
    endtask

    task automatic modelStep();
        if (rst) begin
            mPc = 32'h0; modelBubble(); mHalted = 1'b0; mMis = 1'b0; mBoot = 1'b1;
        end else if (mBoot) begin
            mBoot = 1'b0; modelBubble(); mMis = 1'b0;
        end else if (mHalted) begin
            modelBubble(); mMis = 1'b0;
        end else if (branchTaken) begin
            mPc = branchTarget & 32'hFFFF_FFFC;
            mMis = (branchTarget % 4) != 0;
            modelBubble();
        end else begin
            mMis = 1'b0;
            if (haltReq) begin
                modelBubble(); mHalted = 1'b1;
            end else if (!stall) begin
                if (flush) begin
                    modelBubble();
                end else begin
                    mIfPc = mPc; mIfPc4 = mPc + 32'd4; mIfInstr = imemFn(mPc); mValid = 1'b1;
                end
                mPc = mPc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        modelStep();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        rst = 1'b0; stall = 1'b0; flush = 1'b0; branchTaken = 1'b0;
        haltReq = 1'b0; branchTarget = 32'h0;
    endtask

    task automatic doReset();
        clearInputs(); rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        clearInputs();
        rst = 1'b1; stall = 1'b1; flush = 1'b1; branchTaken = 1'b1;
        haltReq = 1'b1; branchTarget = 32'h0000_0203;
        tick();
        nChecks += 5;
        if (pcOut !== 32'h0) begin nFails++; $display("[TB] FAIL reset_pc got=%h exp=%h", pcOut, 32'h0); end
        if (ifIdInstr !== 32'h13) begin nFails++; $display("[TB] FAIL reset_instr got=%h exp=%h", ifIdInstr, 32'h13); end
        if ({ifIdPc, ifIdPc4} !== 64'h0) begin nFails++; $display("[TB] FAIL reset_ifid_pc got=%h/%h exp=0/0", ifIdPc, ifIdPc4); end
        if ({ifIdValid, halted, misErr} !== 3'b000) begin nFails++; $display("[TB] FAIL reset_flags got=%b exp=000", {ifIdValid, halted, misErr}); end
        if (wPcOut !== 32'hFFFF_FFF8) begin nFails++; $display("[TB] FAIL reset_pc_param got=%h exp=FFFFFFF8", wPcOut); end
        clearInputs();
    endtask

    task automatic test_free_run();
        logic [31:0] expPc   [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        logic        expVal  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [31:0] expIfPc [4] = '{32'h0, 32'h0, 32'h4, 32'h8};
        doReset();
        for (int i = 0; i < 4; i++) begin
            tick();
            nChecks += 3;
            if (pcOut !== expPc[i]) begin nFails++; $display("[TB] FAIL run_pc[%0d] got=%h exp=%h", i, pcOut, expPc[i]); end
            if (ifIdValid !== expVal[i]) begin nFails++; $display("[TB] FAIL run_valid[%0d] got=%b exp=%b", i, ifIdValid, expVal[i]); end
            if (ifIdPc !== expIfPc[i]) begin nFails++; $display("[TB] FAIL run_ifpc[%0d] got=%h exp=%h", i, ifIdPc, expIfPc[i]); end
        end
        nChecks += 2;
        if (ifIdInstr !== imemFn(32'h8)) begin nFails++; $display("[TB] FAIL run_instr got=%h exp=%h", ifIdInstr, imemFn(32'h8)); end
        if (ifIdPc4 !== 32'hC) begin nFails++; $display("[TB] FAIL run_pc4 got=%h exp=%h", ifIdPc4, 32'hC); end
    endtask

    task automatic test_stall();
        doReset();
        tick(); tick(); tick();
        for (int i = 0; i < 2; i++) begin
            stall = 1'b1;
            flush = (i == 1);
            tick();
            nChecks += 3;
            if (pcOut !== 32'h8) begin nFails++; $display("[TB] FAIL stall_pc[%0d] got=%h exp=%h", i, pcOut, 32'h8); end
            if (ifIdPc !== 32'h4 || ifIdValid !== 1'b1) begin nFails++; $display("[TB] FAIL stall_ifid[%0d] got=%h/%b exp=4/1", i, ifIdPc, ifIdValid); end
            if (ifIdInstr !== imemFn(32'h4)) begin nFails++; $display("[TB] FAIL stall_instr[%0d] got=%h exp=%h", i, ifIdInstr, imemFn(32'h4)); end
        end
        clearInputs();
        tick();
        nChecks += 2;
        if (pcOut !== 32'hC) begin nFails++; $display("[TB] FAIL stall_release_pc got=%h exp=%h", pcOut, 32'hC); end
        if (ifIdPc !== 32'h8) begin nFails++; $display("[TB] FAIL stall_release_ifpc got=%h exp=%h", ifIdPc, 32'h8); end
    endtask

    task automatic test_branch();
        stall = 1'b1; branchTaken = 1'b1; branchTarget = 32'h100;
        tick();
        nChecks += 3;
        if (pcOut !== 32'h100) begin nFails++; $display("[TB] FAIL br_pc got=%h exp=%h", pcOut, 32'h100); end
        if (ifIdInstr !== 32'h13 || ifIdValid !== 1'b0) begin nFails++; $display("[TB] FAIL br_bubble got=%h/%b exp=13/0", ifIdInstr, ifIdValid); end
        if (misErr !== 1'b0) begin nFails++; $display("[TB] FAIL br_mis got=%b exp=0", misErr); end
        clearInputs();
        branchTaken = 1'b1; branchTarget = 32'h102;
        tick();
        nChecks += 2;
        if (pcOut !== 32'h100) begin nFails++; $display("[TB] FAIL mis_pc got=%h exp=%h", pcOut, 32'h100); end
        if (misErr !== 1'b1) begin nFails++; $display("[TB] FAIL mis_pulse got=%b exp=1", misErr); end
        clearInputs();
        tick();
        nChecks += 3;
        if (misErr !== 1'b0) begin nFails++; $display("[TB] FAIL mis_clear got=%b exp=0", misErr); end
        if (pcOut !== 32'h104) begin nFails++; $display("[TB] FAIL mis_next_pc got=%h exp=%h", pcOut, 32'h104); end
        if (ifIdPc !== 32'h100 || ifIdValid !== 1'b1) begin nFails++; $display("[TB] FAIL br_fetch got=%h/%b exp=100/1", ifIdPc, ifIdValid); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        tick();
        nChecks += 2;
        if (pcOut !== mPc) begin nFails++; $display("[TB] FAIL flush_pc got=%h exp=%h", pcOut, mPc); end
        if (ifIdValid !== 1'b0 || ifIdInstr !== 32'h13) begin nFails++; $display("[TB] FAIL flush_bubble got=%b/%h exp=0/13", ifIdValid, ifIdInstr); end
        clearInputs();
    endtask

    task automatic test_wrap();
        logic [31:0] expW [4] = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
        doReset();
        nChecks++;
        if (wPcOut !== expW[0]) begin nFails++; $display("[TB] FAIL wrap_pc[0] got=%h exp=%h", wPcOut, expW[0]); end
        for (int i = 1; i < 4; i++) begin
            tick();
            nChecks += 2;
            if (wPcOut !== expW[i]) begin nFails++; $display("[TB] FAIL wrap_pc[%0d] got=%h exp=%h", i, wPcOut, expW[i]); end
            if (wMisErr !== 1'b0) begin nFails++; $display("[TB] FAIL wrap_mis[%0d] got=%b exp=0", i, wMisErr); end
        end
        nChecks++;
        if (wIfIdPc !== 32'hFFFF_FFFC || wIfIdPc4 !== 32'h0) begin nFails++; $display("[TB] FAIL wrap_ifid got=%h/%h exp=FFFFFFFC/0", wIfIdPc, wIfIdPc4); end
    endtask

    task automatic test_halt();
        doReset();
        tick(); tick(); tick(); tick();
        haltReq = 1'b1;
        tick();
        haltReq = 1'b0;
        for (int i = 0; i < 5; i++) begin
            branchTaken = 1'b1; branchTarget = 32'h400 + 32'(i);
            flush = 1'b1;
            nChecks += 3;
            if (halted !== 1'b1) begin nFails++; $display("[TB] FAIL halt_flag[%0d] got=%b exp=1", i, halted); end
            if (pcOut !== 32'hC) begin nFails++; $display("[TB] FAIL halt_pc[%0d] got=%h exp=%h", i, pcOut, 32'hC); end
            if (ifIdValid !== 1'b0 || misErr !== 1'b0) begin nFails++; $display("[TB] FAIL halt_ifid[%0d] got=%b/%b exp=0/0", i, ifIdValid, misErr); end
            tick();
        end
        clearInputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        nChecks += 1;
        if (pcOut !== 32'h0 || halted !== 1'b0) begin nFails++; $display("[TB] FAIL halt_reset got=%h/%b exp=0/0", pcOut, halted); end
    endtask

    task automatic test_back_to_back();
        doReset();
        tick();
        for (int i = 0; i < 8; i++) begin
            branchTaken = 1'b1;
            branchTarget = $urandom;
            tick();
            nChecks += 2;
            if (pcOut !== mPc) begin nFails++; $display("[TB] FAIL b2b_pc[%0d] got=%h exp=%h", i, pcOut, mPc); end
            if (misErr !== mMis || ifIdValid !== 1'b0) begin nFails++; $display("[TB] FAIL b2b_flags[%0d] got=%b/%b exp=%b/0", i, misErr, ifIdValid, mMis); end
        end
        clearInputs();
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            rst          = ($urandom_range(0, 99) < 2);
            stall        = ($urandom_range(0, 99) < 25);
            flush        = ($urandom_range(0, 99) < 20);
            branchTaken  = ($urandom_range(0, 99) < 10);
            haltReq      = ($urandom_range(0, 99) < 2);
            branchTarget = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
            tick();
            nChecks += 4;
            if (pcOut !== mPc) begin nFails++; $display("[TB] FAIL rand_pc[%0d] got=%h exp=%h", i, pcOut, mPc); end
            if ({ifIdPc, ifIdPc4} !== {mIfPc, mIfPc4}) begin nFails++; $display("[TB] FAIL rand_ifpc[%0d] got=%h/%h exp=%h/%h", i, ifIdPc, ifIdPc4, mIfPc, mIfPc4); end
            if (ifIdInstr !== mIfInstr || ifIdValid !== mValid) begin nFails++; $display("[TB] FAIL rand_instr[%0d] got=%h/%b exp=%h/%b", i, ifIdInstr, ifIdValid, mIfInstr, mValid); end
            if (halted !== mHalted || misErr !== mMis) begin nFails++; $display("[TB] FAIL rand_flags[%0d] got=%b/%b exp=%b/%b", i, halted, misErr, mHalted, mMis); end
        end
        clearInputs();
    endtask

    initial begin
        clearInputs();
        mPc = 32'h0; mIfPc = 32'h0; mIfPc4 = 32'h0; mIfInstr = 32'h13;
        mValid = 1'b0; mHalted = 1'b0; mBoot = 1'b1; mMis = 1'b0;
        test_reset();
        test_free_run();
        test_stall();
        test_branch();
        test_flush();
        test_wrap();
        test_halt();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
